// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT byte FIFO behind uart_rx: edge-detected writes, parity flag per entry, sticky overflow.
// Optional build macro UART_RX_BUF_PERR_DROP_EN discards parity-errored bytes and reports them on perr_seen.
module uart_rx_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_ready,
  input  logic [DATA_W-1:0]        rx_byte,
  input  logic                     rx_perr,
  output logic                     rec_ready,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_perr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef UART_RX_BUF_PERR_DROP_EN
  ,
  output logic                     perr_seen
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef UART_RX_BUF_PERR_DROP_EN
  localparam int ENTRY_W = DATA_W;
`else
  localparam int ENTRY_W = DATA_W + 1;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          rx_ready_q;
  logic          overflow_reg;
  logic          rec_ready_reg;

  logic          wr_evt;
  logic          store_evt;
  logic          wr_acc;
  logic          rd_acc;
  logic          drop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  // One write per rising edge of the byte-complete strobe, however long it is held.
  assign wr_evt = rx_ready & ~rx_ready_q;

`ifdef UART_RX_BUF_PERR_DROP_EN
  logic perr_seen_reg;
  assign store_evt = wr_evt & ~rx_perr;
  assign wr_entry  = rx_byte;
`else
  assign store_evt = wr_evt;
  assign wr_entry  = {rx_perr, rx_byte};
`endif

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == DEPTH_C);

  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = store_evt & (~full | rd_en);
  assign drop   = store_evt & full & ~rd_en;

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rx_ready_q    <= 1'b0;
      overflow_reg  <= 1'b0;
      rec_ready_reg <= 1'b1;
    end else begin
      rx_ready_q    <= rx_ready;
      count_reg     <= count_next;
      rec_ready_reg <= (count_next < DEPTH_C);
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BUF_PERR_DROP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_seen_reg <= 1'b0;
    end else if (wr_evt && rx_perr) begin
      perr_seen_reg <= 1'b1;
    end else if (ovf_clr) begin
      perr_seen_reg <= 1'b0;
    end
  end
  assign perr_seen = perr_seen_reg;
`endif

  // Head is read straight from storage so a new byte is visible the cycle after its write.
  assign head      = mem[rd_ptr_reg];
  assign rd_data   = empty ? '0 : head[DATA_W-1:0];
`ifdef UART_RX_BUF_PERR_DROP_EN
  assign rd_perr   = 1'b0;
`else
  assign rd_perr   = empty ? 1'b0 : head[DATA_W];
`endif

  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign rec_ready = rec_ready_reg;

endmodule
